// File: rtl/ysyx_22041207_rd_resp.sv
// Read-response memory model: fixed-latency word read with per-byte lane masking and a range error flag.
// A side write port updates memory in every state.
module ysyx_22041207_rd_resp #(
  parameter logic [63:0] BASE  = 64'h80000000,
  parameter int          DEPTH = 4096,
  parameter int          LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic [63:0] rx_data_read_o,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic        rx_data_err,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb
);

  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH) << 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_data;
  logic        r_err;

  logic [63:0] w_rd_off, w_wr_off, w_mask;
  logic        w_rd_in, w_wr_in, w_hs;
  logic [IW-1:0] w_rd_idx, w_wr_idx;

  assign w_rd_off = rx_r_addr_i - BASE;
  assign w_wr_off = wr_addr - BASE;
  assign w_rd_in  = (rx_r_addr_i >= BASE) && (w_rd_off < LIMIT);
  assign w_wr_in  = (wr_addr >= BASE) && (w_wr_off < LIMIT);
  assign w_rd_idx = w_rd_off[IW+2:3];
  assign w_wr_idx = w_wr_off[IW+2:3];

  assign rx_r_ready_o   = (r_state == IDLE) && !rst;
  assign w_hs           = rx_r_valid_i && rx_r_ready_o;
  assign rx_data_valid  = (r_state == RESP);
  assign rx_data_read_o = r_data;
  assign rx_data_err    = r_err;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_mask[8*i +: 8] = {8{rx_r_size_i[i]}};
    end
  end

  // Memory is intentionally not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && w_wr_in) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_strb[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Snapshot at the handshake edge, so a same-edge write is not visible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_hs) begin
      r_data <= w_rd_in ? (r_mem[w_rd_idx] & w_mask) : '0;
      r_err  <= !w_rd_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (LAT == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(LAT - 2);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rx_data_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041207_rd_resp.sv
// Scoreboard bench for ysyx_22041207_rd_resp: reference word model, latency, hold, range and reset checks.
module tb_ysyx_22041207_rd_resp;

  localparam logic [63:0] BASE  = 64'h80000000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_r_valid_i = 1'b0;
  logic        rx_r_ready_o;
  logic [63:0] rx_r_addr_i = '0;
  logic [7:0]  rx_r_size_i = '0;
  logic [63:0] rx_data_read_o;
  logic        rx_data_valid;
  logic        rx_data_ready = 1'b0;
  logic        rx_data_err;
  logic        wr_en = 1'b0;
  logic [63:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_strb = '0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mdl[int];

  ysyx_22041207_rd_resp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
    .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
    .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .rx_data_err(rx_data_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_read(input logic [63:0] a, input logic [7:0] s);
    exp_t        r;
    logic [63:0] m;
    int          idx;
    m = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    if (a < BASE || a >= LIMIT) begin
      r.d = '0;
      r.e = 1'b1;
    end else begin
      idx = int'((a - BASE) >> 3);
      r.d = mdl.exists(idx) ? (mdl[idx] & m) : 64'd0;
      r.e = 1'b0;
    end
    return r;
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int          idx;
    logic [63:0] w;
    if (a < BASE || a >= LIMIT) return;
    idx = int'((a - BASE) >> 3);
    w = mdl.exists(idx) ? mdl[idx] : 64'd0;
    for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[idx] = w;
  endfunction

  task automatic write_word(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge clk);
    wr_en = 1'b0;
    model_write(a, d, s);
  endtask

  // Issues one read (optionally with a same-edge all-ones write to the same address),
  // waits for valid, holds ready low for 'hold' cycles, then consumes the data.
  task automatic run_read(input logic [63:0] a, input logic [7:0] s, input int hold, input bit we,
                          output logic [63:0] d, output logic e, output int lat,
                          output int unstable, output bit idle_after, output bit hs_rdy);
    @(negedge clk);
    rx_r_valid_i = 1'b1; rx_r_addr_i = a; rx_r_size_i = s; rx_data_ready = 1'b0;
    hs_rdy = (rx_r_ready_o === 1'b1);
    sb.push_back(model_read(a, s));
    if (we) begin
      wr_en = 1'b1; wr_addr = a; wr_data = '1; wr_strb = 8'hFF;
    end
    @(negedge clk);
    rx_r_valid_i = 1'b0;
    wr_en = 1'b0;
    if (we) model_write(a, '1, 8'hFF);
    lat = 1;
    while (rx_data_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = rx_data_read_o;
    e = rx_data_err;
    unstable = 0;
    repeat (hold) begin
      @(negedge clk);
      if (rx_data_valid !== 1'b1 || rx_data_read_o !== d || rx_data_err !== e || rx_r_ready_o !== 1'b0)
        unstable++;
    end
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    idle_after = (rx_data_valid === 1'b0 && rx_r_ready_o === 1'b1);
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (rx_r_ready_o !== 1'b0 || rx_data_valid !== 1'b0 || rx_data_err !== 1'b0 || rx_data_read_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b err=%b data=%h, required 0 0 0 0",
               rx_r_ready_o, rx_data_valid, rx_data_err, rx_data_read_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (rx_r_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b required 1", rx_r_ready_o);
    end
  endtask

  task automatic test_full_read;
    logic [63:0] d; logic e; int lat, un; bit idle, hsr; exp_t x;
    write_word(BASE, 64'h1122334455667788, 8'hFF);
    run_read(BASE, 8'hFF, 0, 1'b0, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL full_latency: got %0d required %0d", lat, LAT); end
    total++;
    if (d !== x.d || d !== 64'h1122334455667788) begin bad++; $display("FAIL full_data: got %h required %h", d, x.d); end
    total++;
    if (e !== x.e) begin bad++; $display("FAIL full_err: got %b required %b", e, x.e); end
    total++;
    if (!idle || !hsr) begin bad++; $display("FAIL full_handshake_idle: hs_rdy=%b idle_after=%b required 1 1", hsr, idle); end
  endtask

  task automatic test_partial;
    logic [63:0] d; logic e; int lat, un; bit idle, hsr; exp_t x;
    run_read(BASE + 64'd4, 8'h0F, 0, 1'b0, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (d !== x.d || d !== 64'h0000000055667788) begin bad++; $display("FAIL partial_data: got %h required %h", d, x.d); end
    run_read(BASE, 8'hA5, 0, 1'b0, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (d !== x.d) begin bad++; $display("FAIL partial_lanes_a5: got %h required %h", d, x.d); end
  endtask

  task automatic test_hold;
    logic [63:0] d; logic e; int lat, un; bit idle, hsr; exp_t x;
    run_read(BASE, 8'hFF, 5, 1'b0, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (un !== 0 || d !== x.d) begin bad++; $display("FAIL hold_stable: unstable=%0d data=%h required 0 %h", un, d, x.d); end
    total++;
    if (!idle) begin bad++; $display("FAIL hold_idle_after: got %b required 1", idle); end
  endtask

  task automatic test_err;
    logic [63:0] d; logic e; int lat, un; bit idle, hsr; exp_t x;
    logic [63:0] addrs[3];
    addrs[0] = 64'h7FFFFFF8;
    addrs[1] = LIMIT;
    addrs[2] = LIMIT - 64'd8;
    write_word(LIMIT - 64'd8, 64'hDEADBEEFCAFEF00D, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      run_read(addrs[i], 8'hFF, 0, 1'b0, d, e, lat, un, idle, hsr);
      x = sb.pop_front();
      total++;
      if (d !== x.d || e !== x.e) begin
        bad++;
        $display("FAIL range_%0d: addr=%h data=%h err=%b required %h %b", i, addrs[i], d, e, x.d, x.e);
      end
    end
  endtask

  task automatic test_same_cycle_write;
    logic [63:0] d; logic e; int lat, un; bit idle, hsr; exp_t x;
    run_read(BASE, 8'hFF, 0, 1'b1, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (d !== x.d || d !== 64'h1122334455667788) begin bad++; $display("FAIL same_cycle_old: got %h required %h", d, x.d); end
    run_read(BASE, 8'hFF, 0, 1'b0, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (d !== x.d || d !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL same_cycle_new: got %h required %h", d, x.d); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d; logic e; int lat, un; bit idle, hsr; exp_t x;
    int vld_seen;
    write_word(BASE + 64'd16, 64'h0F0E0D0C0B0A0908, 8'hFF);
    @(negedge clk);
    rx_r_valid_i = 1'b1; rx_r_addr_i = BASE + 64'd16; rx_r_size_i = 8'hFF;
    @(negedge clk);
    rx_r_valid_i = 1'b0;
    rst = 1'b1;
    // write during reset must be dropped
    wr_en = 1'b1; wr_addr = BASE + 64'd16; wr_data = 64'd0; wr_strb = 8'hFF;
    #1;
    total++;
    if (rx_r_ready_o !== 1'b0 || rx_data_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs: rdy=%b vld=%b required 0 0", rx_r_ready_o, rx_data_valid);
    end
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (rx_r_ready_o !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b required 1", rx_r_ready_o); end
    vld_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rx_data_valid !== 1'b0) vld_seen++;
    end
    total++;
    if (vld_seen !== 0) begin bad++; $display("FAIL mid_reset_no_valid: got %0d valid cycles required 0", vld_seen); end
    run_read(BASE + 64'd16, 8'hFF, 0, 1'b0, d, e, lat, un, idle, hsr);
    x = sb.pop_front();
    total++;
    if (d !== x.d || d !== 64'h0F0E0D0C0B0A0908) begin bad++; $display("FAIL mid_reset_mem_intact: got %h required %h", d, x.d); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] addrs[3];
    int hs, got, last_hs, c;
    bit adv;
    exp_t x;
    write_word(BASE + 64'd8, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    write_word(BASE + 64'd8, 64'h0123456789ABCDEF, 8'h3C);
    addrs[0] = BASE + 64'd8;
    addrs[1] = BASE;
    addrs[2] = LIMIT + 64'd64;
    hs = 0; got = 0; last_hs = -1; adv = 1'b0;
    @(negedge clk);
    rx_r_valid_i = 1'b1; rx_r_addr_i = addrs[0]; rx_r_size_i = 8'hFF; rx_data_ready = 1'b1;
    c = 0;
    while (got < 3 && c < 60) begin
      if (adv) begin
        adv = 1'b0;
        if (hs < 3) rx_r_addr_i = addrs[hs];
        else rx_r_valid_i = 1'b0;
      end
      if (rx_data_valid === 1'b1 && rx_data_ready === 1'b1) begin
        x = sb.pop_front();
        got++;
        total++;
        if (rx_data_read_o !== x.d || rx_data_err !== x.e) begin
          bad++;
          $display("FAIL b2b_data_%0d: data=%h err=%b required %h %b", got, rx_data_read_o, rx_data_err, x.d, x.e);
        end
      end
      if (rx_r_valid_i === 1'b1 && rx_r_ready_o === 1'b1) begin
        sb.push_back(model_read(rx_r_addr_i, rx_r_size_i));
        if (last_hs >= 0) begin
          total++;
          if (c - last_hs !== LAT + 1) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles required %0d", c - last_hs, LAT + 1);
          end
        end
        last_hs = c;
        hs++;
        adv = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    rx_r_valid_i = 1'b0;
    rx_data_ready = 1'b0;
    total++;
    if (got !== 3) begin bad++; $display("FAIL b2b_timeout: got %0d responses required 3", got); end
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_partial();
    test_hold();
    test_err();
    test_same_cycle_write();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
